// File: rtl/axis_bin_pkg.sv
// Shared definitions for the bin write scheduler: command word layout,
// FSM state type and the command word builder.
package axis_bin_pkg;

  localparam int HDR_MSB  = 31;
  localparam int HDR_LSB  = 28;
  localparam int CNT_MSB  = 27;
  localparam int CNT_LSB  = 20;
  localparam int ADDR_MSB = 19;
  localparam int ADDR_LSB = 8;
  localparam int NUM_MSB  = 7;
  localparam int NUM_LSB  = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1
  } state_e;

  function automatic logic [31:0] build_bin_word(input logic [7:0]  cnt,
                                                 input logic [11:0] addr,
                                                 input logic [7:0]  num);
    logic [31:0] w;
    w                   = '0;
    w[HDR_MSB:HDR_LSB]  = 4'h0;
    w[CNT_MSB:CNT_LSB]  = cnt;
    w[ADDR_MSB:ADDR_LSB] = addr;
    w[NUM_MSB:NUM_LSB]  = num;
    return w;
  endfunction

endpackage

// File: rtl/axis_bin_write_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or above
// rr_ptr_i, wrapping modulo NUM_SRC.
module rr_arbiter
  import axis_bin_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int PTR_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [PTR_W-1:0]   rr_ptr_i,
  output logic [NUM_SRC-1:0] grant_o,
  output logic [PTR_W-1:0]   grant_idx_o,
  output logic               grant_valid_o
);

  logic [PTR_W-1:0] idx;

  // Scan from farthest to nearest so the nearest requester is written last.
  always_comb begin
    grant_o       = '0;
    grant_idx_o   = '0;
    grant_valid_o = 1'b0;
    idx           = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      idx = PTR_W'((int'(rr_ptr_i) + k) % NUM_SRC);
      if (req_i[idx]) begin
        grant_o       = '0;
        grant_o[idx]  = 1'b1;
        grant_idx_o   = idx;
        grant_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_bin_write_scheduler.sv
// Round-robin scheduler feeding the binning RAM with {hdr, fill, addr, num}
// command words. Define BIN_WRAP_EN to let a full bin wrap instead of dropping.
module axis_bin_write_scheduler
  import axis_bin_pkg::*;
#(
  parameter int NUM_SRC   = 2,
  parameter int NUM_BINS  = 8,
  parameter int BIN_DEPTH = 32
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [8*NUM_SRC-1:0]   s_axis_tdata,
  input  logic [NUM_SRC-1:0]     s_axis_tvalid,
  output logic [NUM_SRC-1:0]     s_axis_tready,
  output logic [31:0]            m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  input  logic                   clear,
  output logic [NUM_BINS-1:0]    bin_full,
  output logic [15:0]            drop_cnt
);

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int BIN_W = $clog2(NUM_BINS);
  localparam int CNT_W = $clog2(BIN_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BIN_DEPTH);

`ifdef BIN_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  state_e           state_q;
  logic [31:0]      tdata_q;
  logic             tvalid_q;
  logic [PTR_W-1:0] rr_ptr_q;
  logic [PTR_W-1:0] rr_ptr_d;
  logic [15:0]      drop_cnt_q;
  logic [15:0]      drop_cnt_d;

  logic [NUM_SRC-1:0] grant;
  logic [PTR_W-1:0]   grant_idx;
  logic               grant_valid;
  logic               arb_en;
  logic               accept;
  logic [7:0]         number;
  logic [BIN_W-1:0]   bin;
  logic [11:0]        base_addr;
  logic [CNT_W-1:0]   cnt_all [NUM_BINS];
  logic [CNT_W-1:0]   cur_cnt;
  logic               bin_is_full;
  logic               write;
  logic               drop;
  logic [7:0]         fill;

  rr_arbiter #(
    .NUM_SRC (NUM_SRC),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req_i         (s_axis_tvalid),
    .rr_ptr_i      (rr_ptr_q),
    .grant_o       (grant),
    .grant_idx_o   (grant_idx),
    .grant_valid_o (grant_valid)
  );

  assign arb_en        = (state_q == IDLE) && !clear;
  assign accept        = arb_en && grant_valid;
  assign s_axis_tready = arb_en ? grant : '0;

  always_comb begin
    number = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (grant_idx == PTR_W'(k)) number = s_axis_tdata[8*k +: 8];
    end
  end

  assign bin         = number[7 -: BIN_W];
  assign base_addr   = 12'(bin) * 12'(BIN_DEPTH);
  assign cur_cnt     = cnt_all[bin];
  assign bin_is_full = (cur_cnt == DEPTH_C);
  assign write       = accept && (!bin_is_full || WRAP_EN);
  assign drop        = accept && bin_is_full && !WRAP_EN;
  // A wrapping write restarts the bin, overwriting its oldest entry.
  assign fill        = bin_is_full ? 8'h00 : 8'(cur_cnt);
  assign rr_ptr_d    = (int'(grant_idx) == NUM_SRC - 1) ? '0 : grant_idx + PTR_W'(1);
  assign drop_cnt_d  = (drop_cnt_q == 16'hFFFF) ? drop_cnt_q : drop_cnt_q + 16'd1;

  for (genvar gi = 0; gi < NUM_BINS; gi++) begin : g_bin
    logic [CNT_W-1:0] cnt_q;
    logic             full_q;

    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        cnt_q  <= '0;
        full_q <= 1'b0;
      end else begin
        full_q <= (cnt_q == DEPTH_C);
        if (clear) begin
          cnt_q <= '0;
        end else if (write && (bin == BIN_W'(gi))) begin
          cnt_q <= bin_is_full ? CNT_W'(1) : cnt_q + CNT_W'(1);
        end
      end
    end

    assign cnt_all[gi]  = cnt_q;
    assign bin_full[gi] = full_q;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      rr_ptr_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            rr_ptr_q <= rr_ptr_d;
            if (write) begin
              tdata_q  <= build_bin_word(fill, base_addr, number);
              tvalid_q <= 1'b1;
              state_q  <= SEND;
            end else if (drop) begin
              drop_cnt_q <= drop_cnt_d;
            end
          end
        end
        SEND: begin
          if (m_axis_tready) begin
            tvalid_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: begin
          tvalid_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_axis_bin_write_scheduler.sv
// Self-checking bench: vector table, directed corner sequences and a random
// run compared cycle by cycle against a transaction-level reference model.
module tb_axis_bin_write_scheduler;

  localparam int NS    = 2;
  localparam int NB    = 8;
  localparam int DEPTH = 32;
`ifdef BIN_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic            aclk;
  logic            aresetn;
  logic [8*NS-1:0] s_axis_tdata;
  logic [NS-1:0]   s_axis_tvalid;
  logic [NS-1:0]   s_axis_tready;
  logic [31:0]     m_axis_tdata;
  logic            m_axis_tvalid;
  logic            m_axis_tready;
  logic            clear;
  logic [NB-1:0]   bin_full;
  logic [15:0]     drop_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  axis_bin_write_scheduler #(
    .NUM_SRC   (NS),
    .NUM_BINS  (NB),
    .BIN_DEPTH (DEPTH)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .clear         (clear),
    .bin_full      (bin_full),
    .drop_cnt      (drop_cnt)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] word(input int cnt, input int bin, input int num);
    return 32'((cnt << 20) | ((bin * DEPTH) << 8) | num);
  endfunction

  // Reference model: state as seen between clock edges.
  int          m_busy;
  logic [31:0] m_word;
  int          m_rr;
  int          m_drop;
  int          m_cnt [NB];
  logic [NB-1:0] m_full;

  always @(negedge aclk) begin
    int g, num, bin;
    logic [NS-1:0] exp_rdy;
    logic [NB-1:0] nf;
    if (!aresetn) begin
      m_busy = 0; m_word = '0; m_rr = 0; m_drop = 0; m_full = '0;
      for (int b = 0; b < NB; b++) m_cnt[b] = 0;
    end else begin
      g = -1;
      if (m_busy == 0 && !clear)
        for (int k = 0; k < NS; k++)
          if (g < 0 && s_axis_tvalid[(m_rr + k) % NS]) g = (m_rr + k) % NS;
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("mdl_tready", 32'(s_axis_tready), 32'(exp_rdy));
      chk("mdl_tvalid", 32'(m_axis_tvalid), 32'(m_busy));
      if (m_busy != 0) chk("mdl_tdata", m_axis_tdata, m_word);
      chk("mdl_bin_full", 32'(bin_full), 32'(m_full));
      chk("mdl_drop_cnt", 32'(drop_cnt), 32'(m_drop));
      for (int b = 0; b < NB; b++) nf[b] = (m_cnt[b] == DEPTH);
      if (m_busy != 0) begin
        if (m_axis_tready) m_busy = 0;
        if (clear) for (int b = 0; b < NB; b++) m_cnt[b] = 0;
      end else if (clear) begin
        for (int b = 0; b < NB; b++) m_cnt[b] = 0;
      end else if (g >= 0) begin
        num  = int'(s_axis_tdata[8*g +: 8]);
        bin  = num / (256 / NB);
        m_rr = (g + 1) % NS;
        if (m_cnt[bin] < DEPTH) begin
          m_word = word(m_cnt[bin], bin, num);
          m_cnt[bin]++;
          m_busy = 1;
        end else if (WRAP) begin
          m_word = word(0, bin, num);
          m_cnt[bin] = 1;
          m_busy = 1;
        end else if (m_drop < 65535) begin
          m_drop++;
        end
      end
      m_full = nf;
    end
  end

  typedef struct {
    logic [1:0]  tv;
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic        mr;
    logic [1:0]  rdy;
    logic        mv;
    logic [31:0] md;
  } vec_t;

  vec_t tbl [10];

  task automatic set_in(input logic [1:0] tv, input logic [7:0] d0, input logic [7:0] d1,
                        input logic mr, input logic clr);
    s_axis_tvalid = tv;
    s_axis_tdata  = {d1, d0};
    m_axis_tready = mr;
    clear         = clr;
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    set_in(2'b00, 8'h00, 8'h00, 1'b1, 1'b0);
    aresetn = 1'b0;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
  endtask

  task automatic send_one(input logic [7:0] num, input int exp_cnt, input int bin, input bit exp_v,
                          input string nm);
    set_in(2'b01, num, 8'h00, 1'b1, 1'b0);
    step();
    set_in(2'b00, 8'h00, 8'h00, 1'b1, 1'b0);
    @(negedge aclk);
    chk({nm, "_tvalid"}, 32'(m_axis_tvalid), 32'(exp_v));
    if (exp_v) chk({nm, "_word"}, m_axis_tdata, word(exp_cnt, bin, int'(num)));
    step();
  endtask

  initial begin
    tbl[0] = '{2'b01, 8'hA5, 8'h00, 1'b1, 2'b01, 1'b0, 32'h0};
    tbl[1] = '{2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 1'b1, 32'h0000A0A5};
    tbl[2] = '{2'b11, 8'h10, 8'h11, 1'b1, 2'b10, 1'b0, 32'h0};
    tbl[3] = '{2'b11, 8'h10, 8'h11, 1'b1, 2'b00, 1'b1, 32'h00000011};
    tbl[4] = '{2'b11, 8'h10, 8'h11, 1'b1, 2'b01, 1'b0, 32'h0};
    tbl[5] = '{2'b11, 8'h10, 8'h11, 1'b1, 2'b00, 1'b1, 32'h00100010};
    tbl[6] = '{2'b11, 8'h10, 8'h11, 1'b1, 2'b10, 1'b0, 32'h0};
    tbl[7] = '{2'b11, 8'h10, 8'h11, 1'b1, 2'b00, 1'b1, 32'h00200011};
    tbl[8] = '{2'b11, 8'h10, 8'h11, 1'b1, 2'b01, 1'b0, 32'h0};
    tbl[9] = '{2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 1'b1, 32'h00300010};

    aresetn = 1'b0;
    set_in(2'b00, 8'h00, 8'h00, 1'b1, 1'b0);
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;

    @(negedge aclk);
    chk("rst_tdata", m_axis_tdata, 32'h0);
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'h0);
    chk("rst_bin_full", 32'(bin_full), 32'h0);
    step();

    // Single word, then two sources alternating into bin 0.
    for (int i = 0; i < 10; i++) begin
      set_in(tbl[i].tv, tbl[i].d0, tbl[i].d1, tbl[i].mr, 1'b0);
      @(negedge aclk);
      chk($sformatf("tbl%0d_tready", i), 32'(s_axis_tready), 32'(tbl[i].rdy));
      chk($sformatf("tbl%0d_tvalid", i), 32'(m_axis_tvalid), 32'(tbl[i].mv));
      if (tbl[i].mv) chk($sformatf("tbl%0d_tdata", i), m_axis_tdata, tbl[i].md);
      step();
    end

    // Back-pressure: word held stable for 5 stalled cycles, delivered once.
    set_in(2'b01, 8'h2C, 8'h00, 1'b0, 1'b0);
    step();
    set_in(2'b11, 8'h33, 8'h44, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      chk("stall_tvalid", 32'(m_axis_tvalid), 32'h1);
      chk("stall_tdata", m_axis_tdata, 32'h0000202C);
      chk("stall_tready", 32'(s_axis_tready), 32'h0);
      step();
    end
    set_in(2'b00, 8'h00, 8'h00, 1'b1, 1'b0);
    step();
    for (int i = 0; i < 2; i++) begin
      @(negedge aclk);
      chk("stall_once", 32'(m_axis_tvalid), 32'h0);
      step();
    end

    // Fill bin 7, then overflow by one.
    do_reset();
    for (int i = 0; i < 33; i++)
      send_one(8'hE0, (i < DEPTH) ? i : 0, 7, (i < DEPTH) || WRAP, "fill7");
    @(negedge aclk);
    chk("fill7_full", 32'(bin_full[7]), WRAP ? 32'h0 : 32'h1);
    chk("fill7_drop", 32'(drop_cnt), WRAP ? 32'h0 : 32'h1);
    step();

    // Clear while a word is pending.
    do_reset();
    for (int i = 0; i < 4; i++) send_one(8'h40, i, 2, 1'b1, "bin2");
    set_in(2'b01, 8'h40, 8'h00, 1'b0, 1'b0);
    step();
    set_in(2'b00, 8'h00, 8'h00, 1'b0, 1'b1);
    @(negedge aclk);
    chk("clr_pending", m_axis_tdata, 32'h00404040);
    step();
    set_in(2'b00, 8'h00, 8'h00, 1'b1, 1'b0);
    @(negedge aclk);
    chk("clr_held_valid", 32'(m_axis_tvalid), 32'h1);
    chk("clr_held_data", m_axis_tdata, 32'h00404040);
    step();
    send_one(8'h40, 0, 2, 1'b1, "clr_after");

    // Asynchronous reset in the middle of SEND.
    set_in(2'b11, 8'h10, 8'h11, 1'b0, 1'b0);
    step();
    set_in(2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
    step();
    #2 aresetn = 1'b0;
    #1;
    chk("arst_tvalid", 32'(m_axis_tvalid), 32'h0);
    chk("arst_tdata", m_axis_tdata, 32'h0);
    @(posedge aclk);
    #1 aresetn = 1'b1;
    set_in(2'b11, 8'h10, 8'h11, 1'b1, 1'b0);
    @(negedge aclk);
    chk("arst_rr", 32'(s_axis_tready), 32'h1);
    step();
    set_in(2'b00, 8'h00, 8'h00, 1'b1, 1'b0);
    @(negedge aclk);
    chk("arst_cnt", m_axis_tdata, 32'h00000010);
    step();

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      set_in(2'($urandom), 8'($urandom), 8'($urandom),
             $urandom_range(0, 3) != 0, $urandom_range(0, 127) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
